// File: rtl/gcc_batch_sched.sv
// gcc_batch_sched: shares one GCC centroid core between two point-source channels.
// A channel is granted round-robin, the core is cleared, NPTS points are streamed
// from that channel into the core, the active-low core READY_ is awaited, and the
// centroid is returned tagged with the owning channel id.
//
// Optional feature: define GCC_SCHED_TIMEOUT_EN to bound the WAIT phase to TIMEOUT
// cycles; an expired wait yields a result with res_err=1 and a zero centroid.
// Without it, WAIT lasts until the core reports ready and res_err is constant 0.
//
// Handshakes: a point transfers on a cycle where req_valid[c] & req_ready[c] are both
// high (req_ready is one-hot to the granted channel during FEED, zero otherwise); a
// result transfers on a cycle where res_valid & res_ready are both high, and res_*
// hold steady from res_valid rising until that transfer.
module gcc_batch_sched #(
  parameter int NPTS    = 8,
  parameter int TIMEOUT = 64
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [7:0] req0_x,
  input  logic [7:0] req0_y,
  input  logic [3:0] req0_w,
  input  logic [7:0] req1_x,
  input  logic [7:0] req1_y,
  input  logic [3:0] req1_w,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_id,
  output logic [7:0] res_xc,
  output logic [7:0] res_yc,
  output logic       res_err,
  output logic       core_rst,
  output logic       core_load,
  output logic [7:0] core_x,
  output logic [7:0] core_y,
  output logic [3:0] core_w,
  input  logic       core_ready_n,
  input  logic [7:0] core_xc,
  input  logic [7:0] core_yc,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_CLR   = 3'd2,
    S_FEED  = 3'd3,
    S_WAIT  = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  localparam logic [7:0] LAST_BEAT = 8'(NPTS - 1);

  state_t     state_q;
  logic       gnt_q;
  logic       last_q;
  logic [7:0] cnt_q;
  logic       res_valid_q;
  logic       res_id_q;
  logic [7:0] res_xc_q;
  logic [7:0] res_yc_q;
  logic       core_rst_q;
  logic       pick_d;
  logic       beat;

`ifdef GCC_SCHED_TIMEOUT_EN
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);
  logic [7:0] wcnt_q;
  logic       res_err_q;
  assign res_err = res_err_q;
`else
  assign res_err = 1'b0;
`endif

  // Round-robin pick: a lone requester wins, a tie goes away from the last grant.
  always_comb begin
    pick_d = req_valid[1];
    if (req_valid == 2'b11) pick_d = ~last_q;
  end

  // FEED datapath: ready to the granted channel, point forwarded only on a beat.
  always_comb begin
    req_ready = 2'b00;
    if (state_q == S_FEED) req_ready = gnt_q ? 2'b10 : 2'b01;
    beat      = |(req_valid & req_ready);
    core_load = beat;
    core_x    = 8'd0;
    core_y    = 8'd0;
    core_w    = 4'd0;
    if (beat) begin
      core_x = gnt_q ? req1_x : req0_x;
      core_y = gnt_q ? req1_y : req0_y;
      core_w = gnt_q ? req1_w : req0_w;
    end
  end

  // Batch sequencer: arbitration, core clear, beat counting, result capture.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      gnt_q       <= 1'b0;
      last_q      <= 1'b1;  // makes ch0 the first tie winner
      cnt_q       <= 8'd0;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_xc_q    <= 8'd0;
      res_yc_q    <= 8'd0;
      core_rst_q  <= 1'b0;
`ifdef GCC_SCHED_TIMEOUT_EN
      wcnt_q      <= 8'd0;
      res_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|req_valid) begin
            gnt_q   <= pick_d;
            last_q  <= pick_d;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          core_rst_q <= 1'b1;  // high for exactly the CLR cycle
          cnt_q      <= 8'd0;
          state_q    <= S_CLR;
        end
        S_CLR: begin
          core_rst_q <= 1'b0;
`ifdef GCC_SCHED_TIMEOUT_EN
          wcnt_q     <= 8'd0;
`endif
          state_q    <= S_FEED;
        end
        S_FEED: begin
          if (beat) begin
            if (cnt_q == LAST_BEAT) begin
              cnt_q   <= 8'd0;
              state_q <= S_WAIT;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        S_WAIT: begin
          if (!core_ready_n) begin
            res_xc_q    <= core_xc;
            res_yc_q    <= core_yc;
            res_id_q    <= gnt_q;
            res_valid_q <= 1'b1;
`ifdef GCC_SCHED_TIMEOUT_EN
            res_err_q   <= 1'b0;
`endif
            state_q     <= S_RESP;
          end
`ifdef GCC_SCHED_TIMEOUT_EN
          else if (wcnt_q == LAST_WAIT) begin
            res_xc_q    <= 8'd0;
            res_yc_q    <= 8'd0;
            res_id_q    <= gnt_q;
            res_err_q   <= 1'b1;
            res_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            wcnt_q <= wcnt_q + 8'd1;
          end
`endif
        end
        S_RESP: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_xc    = res_xc_q;
  assign res_yc    = res_yc_q;
  assign core_rst  = core_rst_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gcc_batch_sched.sv
// Directed bench for gcc_batch_sched: single-channel batch, round-robin, valid gaps,
// result back-pressure, mid-batch reset and the WAIT timeout (GCC_SCHED_TIMEOUT_EN).
module tb_gcc_batch_sched;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req0_x, req0_y, req1_x, req1_y;
  logic [3:0] req0_w, req1_w;
  logic       res_valid, res_ready, res_id, res_err;
  logic [7:0] res_xc, res_yc;
  logic       core_rst, core_load;
  logic [7:0] core_x, core_y;
  logic [3:0] core_w;
  logic       core_ready_n;
  logic [7:0] core_xc, core_yc;
  logic [2:0] dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  gcc_batch_sched dut (
    .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .req_ready(req_ready),
    .req0_x(req0_x), .req0_y(req0_y), .req0_w(req0_w),
    .req1_x(req1_x), .req1_y(req1_y), .req1_w(req1_w),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_xc(res_xc), .res_yc(res_yc), .res_err(res_err),
    .core_rst(core_rst), .core_load(core_load),
    .core_x(core_x), .core_y(core_y), .core_w(core_w),
    .core_ready_n(core_ready_n), .core_xc(core_xc), .core_yc(core_yc),
    .dbg_state(dbg_state)
  );

  // batch observation log filled by run_batch
  logic [7:0] load_x_q[$];
  logic [7:0] load_y_q[$];
  logic [3:0] load_w_q[$];
  logic       load_ch_q[$];
  int n_rst, n_loads, n_bad_idle, res_iter, last_load_iter;
  bit res_seen;
  logic [7:0] cur_xc, cur_yc;

  function automatic logic [7:0] pt_x(input logic c, input int i);
    return c ? 8'(100 + i) : 8'(10 + i);
  endfunction
  function automatic logic [7:0] pt_y(input logic c, input int i);
    return c ? 8'(120 + i) : 8'(20 + i);
  endfunction
  function automatic logic [3:0] pt_w(input logic c);
    return c ? 4'd2 : 4'd1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    req_valid = 2'b00; res_ready = 1'b0; core_ready_n = 1'b1;
    req0_x = 0; req0_y = 0; req0_w = 0; req1_x = 0; req1_y = 0; req1_w = 0;
    core_xc = 0; core_yc = 0;
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  // Drives sources and a core model until res_valid shows or the budget expires.
  // The core reports ready core_lat cycles after the last load (core_lat=0: never).
  task automatic run_batch(input logic [1:0] mask, input int gap_beat, input int gap_len,
                           input int core_lat, input int budget);
    int idx[2];
    int gap_cnt;
    int since;
    logic [1:0] v;
    load_x_q.delete(); load_y_q.delete(); load_w_q.delete(); load_ch_q.delete();
    n_rst = 0; n_loads = 0; n_bad_idle = 0; res_seen = 0; res_iter = -1;
    last_load_iter = -1; since = 0; idx[0] = 0; idx[1] = 0; gap_cnt = 0;
    for (int it = 0; it < budget; it++) begin
      @(negedge CLK);
      if (n_loads >= 8) since++;
      core_ready_n = !(n_loads >= 8 && core_lat > 0 && since >= core_lat);
      core_xc = cur_xc; core_yc = cur_yc;
      v = mask;
      for (int c = 0; c < 2; c++)
        if (mask[c] && idx[c] == gap_beat && gap_cnt < gap_len) begin
          v[c] = 1'b0; gap_cnt++;
        end
      req_valid = v;
      req0_x = pt_x(1'b0, idx[0]); req0_y = pt_y(1'b0, idx[0]); req0_w = pt_w(1'b0);
      req1_x = pt_x(1'b1, idx[1]); req1_y = pt_y(1'b1, idx[1]); req1_w = pt_w(1'b1);
      #1;
      if (core_rst) n_rst++;
      if (core_load) begin
        load_x_q.push_back(core_x); load_y_q.push_back(core_y);
        load_w_q.push_back(core_w); load_ch_q.push_back(req_ready[1]);
        n_loads++; last_load_iter = it;
      end else if (core_x != 0 || core_y != 0 || core_w != 0) begin
        n_bad_idle++;
      end
      for (int c = 0; c < 2; c++)
        if (req_valid[c] && req_ready[c]) idx[c]++;
      if (res_valid) begin
        res_seen = 1; res_iter = it;
        break;
      end
    end
  endtask

  task automatic accept();
    res_ready = 1'b1;
    @(negedge CLK);
    res_ready = 1'b0;
    core_ready_n = 1'b1;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    apply_reset();
    RESET = 1'b1;
    @(negedge CLK); #1;
    tests_run++;
    if ({res_valid, res_id, res_err, core_rst, core_load, req_ready} !== 7'd0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {res_valid, res_id, res_err, core_rst, core_load, req_ready});
    end
    tests_run++;
    if ({res_xc, res_yc, core_x, core_y, core_w} !== 36'd0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h expected 0", {res_xc, res_yc, core_x, core_y, core_w});
    end
    tests_run++;
    if (dbg_state !== 3'd0) begin
      tests_failed++; $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    RESET = 1'b0;
  endtask

  task automatic test_single_ch0();
    int bad = 0;
    cur_xc = 8'h3C; cur_yc = 8'h5A;
    run_batch(2'b01, -1, 0, 3, 100);
    tests_run++;
    if (!res_seen) begin tests_failed++; $display("FAIL t1_res_seen: got 0 expected 1"); end
    tests_run++;
    if (n_rst !== 1) begin tests_failed++; $display("FAIL t1_core_rst: got %0d pulses expected 1", n_rst); end
    tests_run++;
    if (n_loads !== 8) begin tests_failed++; $display("FAIL t1_loads: got %0d expected 8", n_loads); end
    foreach (load_x_q[i])
      if (load_x_q[i] !== 8'(10 + i) || load_y_q[i] !== 8'(20 + i) ||
          load_w_q[i] !== 4'd1 || load_ch_q[i] !== 1'b0) bad++;
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL t1_load_order: got %0d bad loads expected 0", bad); end
    tests_run++;
    if (n_bad_idle !== 0) begin tests_failed++; $display("FAIL t1_idle_data: got %0d nonzero cycles expected 0", n_bad_idle); end
    tests_run++;
    if ({res_id, res_err, res_xc, res_yc} !== {1'b0, 1'b0, 8'h3C, 8'h5A}) begin
      tests_failed++;
      $display("FAIL t1_result: got id=%0d err=%0d xc=%h yc=%h expected id=0 err=0 xc=3c yc=5a",
               res_id, res_err, res_xc, res_yc);
    end
    tests_run++;
    if (res_iter !== 14) begin tests_failed++; $display("FAIL t1_latency: got %0d expected 14", res_iter); end
    accept();
    req_valid = 2'b00;
  endtask

  task automatic test_round_robin();
    logic exp_id[3];
    exp_id[0] = 1'b0; exp_id[1] = 1'b1; exp_id[2] = 1'b0;
    apply_reset();
    for (int b = 0; b < 3; b++) begin
      cur_xc = 8'(8'h40 + b); cur_yc = 8'(8'h80 + b);
      run_batch(2'b11, -1, 0, 2, 100);
      tests_run++;
      if (!res_seen || res_id !== exp_id[b] || res_xc !== cur_xc) begin
        tests_failed++;
        $display("FAIL t2_rr_batch%0d: got seen=%0d id=%0d xc=%h expected seen=1 id=%0d xc=%h",
                 b, res_seen, res_id, res_xc, exp_id[b], cur_xc);
      end
      tests_run++;
      if (n_loads !== 8 || load_x_q[0] !== pt_x(exp_id[b], 0) || load_ch_q[7] !== exp_id[b]) begin
        tests_failed++;
        $display("FAIL t2_rr_loads%0d: got n=%0d x0=%h expected n=8 x0=%h",
                 b, n_loads, load_x_q[0], pt_x(exp_id[b], 0));
      end
      accept();
    end
    req_valid = 2'b00;
  endtask

  task automatic test_valid_gap();
    int bad = 0;
    cur_xc = 8'h77; cur_yc = 8'h66;
    run_batch(2'b10, 4, 5, 2, 100);
    tests_run++;
    if (n_loads !== 8) begin tests_failed++; $display("FAIL t3_loads: got %0d expected 8", n_loads); end
    foreach (load_x_q[i])
      if (load_x_q[i] !== 8'(100 + i) || load_y_q[i] !== 8'(120 + i) || load_w_q[i] !== 4'd2) bad++;
    tests_run++;
    if (bad !== 0 || n_bad_idle !== 0) begin
      tests_failed++; $display("FAIL t3_gap_data: got %0d bad loads %0d bad idle expected 0 0", bad, n_bad_idle);
    end
    tests_run++;
    if ({res_seen, res_id, res_err} !== 3'b110) begin
      tests_failed++; $display("FAIL t3_result: got seen/id/err=%b expected 110", {res_seen, res_id, res_err});
    end
    tests_run++;
    if (res_iter !== 18) begin tests_failed++; $display("FAIL t3_latency: got %0d expected 18", res_iter); end
    accept();
    req_valid = 2'b00;
  endtask

  task automatic test_resp_hold();
    int unstable = 0;
    int leaked = 0;
    cur_xc = 8'h91; cur_yc = 8'h19;
    run_batch(2'b01, -1, 0, 1, 100);
    req_valid = 2'b11;
    core_ready_n = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      core_xc = 8'(k); core_yc = 8'(k);
      #1;
      if (res_valid !== 1'b1 || res_id !== 1'b0 || res_xc !== 8'h91 || res_yc !== 8'h19 ||
          res_err !== 1'b0) unstable++;
      if (req_ready !== 2'b00 || core_load !== 1'b0 || dbg_state !== 3'd5) leaked++;
    end
    tests_run++;
    if (unstable !== 0) begin tests_failed++; $display("FAIL t4_res_stable: got %0d unstable cycles expected 0", unstable); end
    tests_run++;
    if (leaked !== 0) begin tests_failed++; $display("FAIL t4_no_grant: got %0d busy cycles expected 0", leaked); end
    res_ready = 1'b1;
    @(negedge CLK);
    res_ready = 1'b0; core_ready_n = 1'b1;
    #1;
    tests_run++;
    if ({res_valid, dbg_state, req_ready} !== 6'b0_000_00) begin
      tests_failed++;
      $display("FAIL t4_after_accept: got valid=%0d state=%0d ready=%b expected 0 0 00",
               res_valid, dbg_state, req_ready);
    end
    @(negedge CLK); #1;
    tests_run++;
    if (dbg_state !== 3'd1) begin tests_failed++; $display("FAIL t4_regrant: got state %0d expected 1", dbg_state); end
    cur_xc = 8'h2B; cur_yc = 8'hB2;
    run_batch(2'b11, -1, 0, 1, 100);
    tests_run++;
    if (!res_seen || res_id !== 1'b1 || n_loads !== 8) begin
      tests_failed++; $display("FAIL t4_next_batch: got seen=%0d id=%0d n=%0d expected 1 1 8", res_seen, res_id, n_loads);
    end
    accept();
    req_valid = 2'b00;
  endtask

  task automatic test_reset_mid();
    int idx = 0;
    for (int it = 0; it < 40 && idx < 4; it++) begin
      @(negedge CLK);
      req_valid = 2'b01;
      req0_x = pt_x(1'b0, idx); req0_y = pt_y(1'b0, idx); req0_w = pt_w(1'b0);
      #1;
      if (core_load) begin
        idx++;
        if (idx == 4) RESET = 1'b1;
      end
    end
    tests_run++;
    if (idx !== 4) begin tests_failed++; $display("FAIL t5_reach_beat4: got %0d beats expected 4", idx); end
    @(negedge CLK); #1;
    tests_run++;
    if ({res_valid, res_id, res_err, core_rst, core_load, req_ready, dbg_state} !== 10'd0 ||
        {res_xc, res_yc, core_x, core_y, core_w} !== 36'd0) begin
      tests_failed++;
      $display("FAIL t5_mid_reset: got ctl=%b data=%h expected all 0",
               {res_valid, res_id, res_err, core_rst, core_load, req_ready, dbg_state},
               {res_xc, res_yc, core_x, core_y, core_w});
    end
    RESET = 1'b0; req_valid = 2'b00;
    cur_xc = 8'hC3; cur_yc = 8'h3C;
    run_batch(2'b01, -1, 0, 2, 100);
    tests_run++;
    if (!res_seen || res_id !== 1'b0 || n_loads !== 8 || n_rst !== 1 || load_x_q[0] !== 8'd10 ||
        res_xc !== 8'hC3) begin
      tests_failed++;
      $display("FAIL t5_fresh_batch: got seen=%0d id=%0d n=%0d rst=%0d xc=%h expected 1 0 8 1 c3",
               res_seen, res_id, n_loads, n_rst, res_xc);
    end
    accept();
    req_valid = 2'b00;
  endtask

  task automatic test_timeout();
    cur_xc = 8'hEE; cur_yc = 8'hDD;
`ifdef GCC_SCHED_TIMEOUT_EN
    run_batch(2'b01, -1, 0, 0, 150);
    tests_run++;
    if (!res_seen || res_iter - (last_load_iter + 1) !== 64) begin
      tests_failed++;
      $display("FAIL t6_timeout_delay: got seen=%0d delay=%0d expected 1 64",
               res_seen, res_iter - (last_load_iter + 1));
    end
    tests_run++;
    if ({res_err, res_id, res_xc, res_yc} !== {1'b1, 1'b0, 8'h00, 8'h00}) begin
      tests_failed++;
      $display("FAIL t6_timeout_result: got err=%0d id=%0d xc=%h yc=%h expected 1 0 00 00",
               res_err, res_id, res_xc, res_yc);
    end
    accept();
    run_batch(2'b01, -1, 0, 2, 100);
    tests_run++;
    if (!res_seen || res_err !== 1'b0 || n_rst !== 1 || res_xc !== 8'hEE) begin
      tests_failed++;
      $display("FAIL t6_after_timeout: got seen=%0d err=%0d rst=%0d xc=%h expected 1 0 1 ee",
               res_seen, res_err, n_rst, res_xc);
    end
    accept();
`else
    run_batch(2'b01, -1, 0, 0, 215);
    tests_run++;
    if (res_seen || n_loads !== 8 || dbg_state !== 3'd4 || res_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL t6_no_timeout: got seen=%0d n=%0d state=%0d err=%0d expected 0 8 4 0",
               res_seen, n_loads, dbg_state, res_err);
    end
    apply_reset();
`endif
    req_valid = 2'b00;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_ch0();
    test_round_robin();
    test_valid_gap();
    test_resp_hold();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
